// File: rtl/uart_tx_scheduler.sv
// Two-requester round-robin UART transmitter: 8N1 by default, 8E1 when UART_TX_PARITY_EN
// is defined; GAP_TICKS idle bit periods follow each stop bit.
module uart_tx_scheduler #(
    parameter int unsigned GAP_TICKS = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       tx,
    output logic       busy,
    output logic       grant_id
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP,
        GAP
    } TxState;

    localparam logic [3:0] GAP_LAST = 4'(GAP_TICKS - 1);

    TxState     r_state;
    logic [2:0] r_bitIdx;
    logic [3:0] r_gapCnt;
    logic [7:0] r_data;
    logic       r_tx;
    logic       r_ack0;
    logic       r_ack1;
    logic       r_busy;
    logic       r_grantId;
    logic       r_lastGrant;

    TxState     w_nextState;
    logic [2:0] w_nextBitIdx;
    logic [3:0] w_nextGapCnt;
    logic [7:0] w_nextData;
    logic       w_nextTx;
    logic       w_nextAck0;
    logic       w_nextAck1;
    logic       w_nextBusy;
    logic       w_nextGrantId;
    logic       w_nextLastGrant;
    logic       w_pick1;

    // r_lastGrant starts at 1 so that requester 0 wins the first tie.
    assign w_pick1 = req1 && (!req0 || !r_lastGrant);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bitIdx    <= 3'd0;
            r_gapCnt    <= 4'd0;
            r_data      <= 8'h00;
            r_tx        <= 1'b1;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_busy      <= 1'b0;
            r_grantId   <= 1'b0;
            r_lastGrant <= 1'b1;
        end else begin
            r_state     <= w_nextState;
            r_bitIdx    <= w_nextBitIdx;
            r_gapCnt    <= w_nextGapCnt;
            r_data      <= w_nextData;
            r_tx        <= w_nextTx;
            r_ack0      <= w_nextAck0;
            r_ack1      <= w_nextAck1;
            r_busy      <= w_nextBusy;
            r_grantId   <= w_nextGrantId;
            r_lastGrant <= w_nextLastGrant;
        end
    end

    always_comb begin
        w_nextState     = r_state;
        w_nextBitIdx    = r_bitIdx;
        w_nextGapCnt    = r_gapCnt;
        w_nextData      = r_data;
        w_nextTx        = r_tx;
        w_nextAck0      = 1'b0;
        w_nextAck1      = 1'b0;
        w_nextBusy      = r_busy;
        w_nextGrantId   = r_grantId;
        w_nextLastGrant = r_lastGrant;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_nextData      = w_pick1 ? data1 : data0;
                    w_nextAck0      = !w_pick1;
                    w_nextAck1      = w_pick1;
                    w_nextGrantId   = w_pick1;
                    w_nextLastGrant = w_pick1;
                    w_nextBusy      = 1'b1;
                    w_nextState     = ARM;
                end
            end
            // Only ticks after the capture cycle count, so the start bit is a full period.
            ARM: begin
                if (baud_tick) begin
                    w_nextTx    = 1'b0;
                    w_nextState = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    w_nextBitIdx = 3'd0;
                    w_nextTx     = r_data[0];
                    w_nextState  = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (r_bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_nextTx    = ^r_data;
                        w_nextState = PARITY;
`else
                        w_nextTx    = 1'b1;
                        w_nextState = STOP;
`endif
                    end else begin
                        w_nextBitIdx = r_bitIdx + 3'd1;
                        w_nextTx     = r_data[r_bitIdx + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    w_nextTx    = 1'b1;
                    w_nextState = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    w_nextTx = 1'b1;
                    if (GAP_TICKS > 0) begin
                        w_nextGapCnt = 4'd0;
                        w_nextState  = GAP;
                    end else begin
                        w_nextBusy  = 1'b0;
                        w_nextState = IDLE;
                    end
                end
            end
            GAP: begin
                if (baud_tick) begin
                    if (r_gapCnt == GAP_LAST) begin
                        w_nextBusy  = 1'b0;
                        w_nextState = IDLE;
                    end else begin
                        w_nextGapCnt = r_gapCnt + 4'd1;
                    end
                end
            end
            default: begin
                w_nextTx    = 1'b1;
                w_nextBusy  = 1'b0;
                w_nextState = IDLE;
            end
        endcase
    end

    assign tx       = r_tx;
    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign busy     = r_busy;
    assign grant_id = r_grantId;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: two copies (GAP_TICKS 0 and 2) share clock, reset
// and baud_tick; a tick-counting frame model predicts tx/busy/ack/grant_id every cycle.
module tb_uart_tx_scheduler;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int GAP1 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic baudTick = 1'b0;
    logic [1:0] req0, req1;
    logic [1:0][7:0] data0, data1;
    logic [1:0] ack0, ack1, txLine, busy, grantId;

    int nChecks = 0;
    int nFails = 0;

    // Frame-level model: state is just "busy or not", ticks since capture and the byte.
    bit [1:0] mValid, mBusy, mGrant, mLast, mTx, mAck0, mAck1;
    int mTicks[2];
    logic [7:0] mByte[2];
    logic [7:0] q00[$], q01[$], q10[$], q11[$];

    int tickPeriod, tickCnt, raisePct, withdrawPct, resetPer10k;
    bit persistent;
    bit pend[2][2];

    uart_tx_scheduler #(.GAP_TICKS(0)) dutGap0 (
        .clk(clk), .rst(rst), .baud_tick(baudTick),
        .req0(req0[0]), .req1(req1[0]), .data0(data0[0]), .data1(data1[0]),
        .ack0(ack0[0]), .ack1(ack1[0]), .tx(txLine[0]), .busy(busy[0]), .grant_id(grantId[0])
    );

    uart_tx_scheduler #(.GAP_TICKS(GAP1)) dutGap2 (
        .clk(clk), .rst(rst), .baud_tick(baudTick),
        .req0(req0[1]), .req1(req1[1]), .data0(data0[1]), .data1(data1[1]),
        .ack0(ack0[1]), .ack1(ack1[1]), .tx(txLine[1]), .busy(busy[1]), .grant_id(grantId[1])
    );

    always #5 clk = ~clk;

    function automatic int frameTicks(input int i);
        return 11 + PAR + ((i == 0) ? 0 : GAP1);
    endfunction

    // Line level expected after the k-th tick following capture.
    function automatic logic txForTick(input int k, input logic [7:0] b);
        logic [7:0] bits;
        bits = b;
        if (k == 1) return 1'b0;
        if (k >= 2 && k <= 9) return bits[3'(k - 2)];
        if (PAR == 1 && k == 10) return ^bits;
        return 1'b1;
    endfunction

    task automatic pushQ(input int i, input int s, input logic [7:0] d);
        case ({i[0], s[0]})
            2'b00: q00.push_back(d);
            2'b01: q01.push_back(d);
            2'b10: q10.push_back(d);
            default: q11.push_back(d);
        endcase
    endtask

    task automatic popFrontQ(input int i, input int s, output bit ok, output logic [7:0] d);
        ok = 1'b0;
        d = 8'h00;
        case ({i[0], s[0]})
            2'b00: if (q00.size() > 0) begin d = q00.pop_front(); ok = 1'b1; end
            2'b01: if (q01.size() > 0) begin d = q01.pop_front(); ok = 1'b1; end
            2'b10: if (q10.size() > 0) begin d = q10.pop_front(); ok = 1'b1; end
            default: if (q11.size() > 0) begin d = q11.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic popBackQ(input int i, input int s);
        case ({i[0], s[0]})
            2'b00: if (q00.size() > 0) q00.pop_back();
            2'b01: if (q01.size() > 0) q01.pop_back();
            2'b10: if (q10.size() > 0) q10.pop_back();
            default: if (q11.size() > 0) q11.pop_back();
        endcase
    endtask

    task automatic checkBit(input string name, input int i, input logic act, input logic exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s dut%0d at %0t: got %b, expected %b", name, i, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input int i);
        if (mValid[i]) begin
            checkBit("tx", i, txLine[i], mTx[i]);
            checkBit("busy", i, busy[i], mBusy[i]);
            checkBit("ack0", i, ack0[i], mAck0[i]);
            checkBit("ack1", i, ack1[i], mAck1[i]);
            checkBit("grant_id", i, grantId[i], mGrant[i]);
        end
    endtask

    task automatic predictEdge(input int i);
        bit ok;
        bit win;
        logic [7:0] d;
        mAck0[i] = 1'b0;
        mAck1[i] = 1'b0;
        if (rst) begin
            mValid[i] = 1'b1;
            mBusy[i]  = 1'b0;
            mTx[i]    = 1'b1;
            mGrant[i] = 1'b0;
            mLast[i]  = 1'b1;
            mTicks[i] = 0;
        end else if (mValid[i] && !mBusy[i]) begin
            if (req0[i] || req1[i]) begin
                win = (req0[i] && req1[i]) ? !mLast[i] : req1[i];
                popFrontQ(i, int'(win), ok, d);
                nChecks++;
                if (!ok) begin
                    nFails++;
                    $display("[TB] FAIL scoreboard dut%0d at %0t: got capture of req%0d, expected a queued byte", i, $time, win);
                end
                mByte[i]  = d;
                mAck0[i]  = !win;
                mAck1[i]  = win;
                mGrant[i] = win;
                mLast[i]  = win;
                mBusy[i]  = 1'b1;
                mTicks[i] = 0;
            end
        end else if (mValid[i] && baudTick) begin
            mTicks[i]++;
            mTx[i] = txForTick(mTicks[i], mByte[i]);
            if (mTicks[i] == frameTicks(i)) mBusy[i] = 1'b0;
        end
    endtask

    // Monitor: compare what the last edge produced, then predict the next edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            checkOutput(i);
            predictEdge(i);
        end
    end

    task automatic setReq(input int i, input int s, input logic v);
        if (s == 0) req0[i] = v;
        else req1[i] = v;
    endtask

    task automatic raiseReq(input int i, input int s, input logic [7:0] d);
        if (s == 0) data0[i] = d;
        else data1[i] = d;
        setReq(i, s, 1'b1);
        pend[i][s] = 1'b1;
        pushQ(i, s, d);
    endtask

    task automatic raiseBoth(input int s, input logic [7:0] d);
        for (int i = 0; i < 2; i++) raiseReq(i, s, d);
    endtask

    task automatic withdrawAll();
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 2; s++) begin
                if (pend[i][s]) begin
                    setReq(i, s, 1'b0);
                    pend[i][s] = 1'b0;
                    popBackQ(i, s);
                end
            end
        end
    endtask

    task automatic driveRequester(input int i, input int s);
        logic a;
        logic [7:0] d;
        a = (s == 0) ? ack0[i] : ack1[i];
        d = (s == 0) ? data0[i] : data1[i];
        if (pend[i][s] && a === 1'b1) begin
            if (persistent) begin
                pushQ(i, s, d);
            end else begin
                setReq(i, s, 1'b0);
                pend[i][s] = 1'b0;
            end
        end else if (pend[i][s]) begin
            if (int'($urandom_range(99)) < withdrawPct) begin
                setReq(i, s, 1'b0);
                pend[i][s] = 1'b0;
                popBackQ(i, s);
            end
        end else if (int'($urandom_range(99)) < raisePct) begin
            raiseReq(i, s, 8'($urandom));
        end
    endtask

    task automatic applyStimulus(input bit forceRst);
        @(posedge clk);
        #1;
        if (tickPeriod > 0) begin
            tickCnt = (tickCnt + 1) % tickPeriod;
            baudTick = (tickCnt == 0);
        end else begin
            baudTick = ($urandom_range(3) == 0);
        end
        rst = forceRst || (resetPer10k > 0 && int'($urandom_range(9999)) < resetPer10k);
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 2; s++) driveRequester(i, s);
        end
    endtask

    initial begin
        logic [7:0] dirBytes[3];
        int budget;
        int ticks;
        dirBytes = '{8'hA5, 8'h07, 8'h03};
        req0 = '0;
        req1 = '0;
        data0 = '0;
        data1 = '0;
        tickPeriod = 16;
        tickCnt = 0;
        raisePct = 0;
        withdrawPct = 0;
        resetPer10k = 0;
        persistent = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 2; s++) pend[i][s] = 1'b0;
        end
        repeat (3) applyStimulus(1'b1);

        // Lone requests; the first is raised while rst is still high.
        for (int k = 0; k < 3; k++) begin
            raiseBoth((k == 2) ? 1 : 0, dirBytes[k]);
            repeat (300) applyStimulus(1'b0);
        end

        // Requests raised so that capture coincides with a baud tick.
        for (int k = 0; k < 2; k++) begin
            budget = 0;
            do begin
                applyStimulus(1'b0);
                budget++;
            end while (!baudTick && budget < 40);
            raiseBoth(k, 8'(8'h3C + k));
            repeat (300) applyStimulus(1'b0);
        end

        // Both requesters held high: frames must alternate starting with req0.
        persistent = 1'b1;
        raiseBoth(0, 8'h11);
        raiseBoth(1, 8'h22);
        repeat (900) applyStimulus(1'b0);

        // Reset during data bit 3 of the next frame on the GAP_TICKS=0 copy.
        budget = 0;
        do begin
            applyStimulus(1'b0);
            budget++;
        end while (!(ack0[0] || ack1[0]) && budget < 600);
        nChecks++;
        if (!(ack0[0] || ack1[0])) begin
            nFails++;
            $display("[TB] FAIL capture-timeout: got no ack within 600 cycles, expected one");
        end
        ticks = baudTick ? 1 : 0;
        budget = 0;
        while (ticks < 5 && budget < 200) begin
            applyStimulus(1'b0);
            budget++;
            if (baudTick) ticks++;
        end
        applyStimulus(1'b1);
        repeat (400) applyStimulus(1'b0);
        persistent = 1'b0;
        applyStimulus(1'b0);
        withdrawAll();
        repeat (300) applyStimulus(1'b0);

        // Randomized traffic with withdrawals and occasional resets.
        raisePct = 10;
        withdrawPct = 1;
        resetPer10k = 5;
        tickPeriod = 0;
        repeat (8000) applyStimulus(1'b0);
        tickPeriod = 3;
        tickCnt = 0;
        repeat (4000) applyStimulus(1'b0);
        raisePct = 0;
        resetPer10k = 0;
        withdrawAll();
        repeat (300) applyStimulus(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
